// File: rtl/jpeg_byte_stuffer.sv
// JPEG entropy-stream tail: packs MSB-first variable-length codes into bytes,
// stuffs 0x00 after every data 0xFF, and closes each frame with 1-padding plus EOI (FF D9).
module jpeg_byte_stuffer #(
  parameter int unsigned CODE_W = 64,
  parameter int unsigned ACC_W  = 128,
  parameter int unsigned SIZE_W = $clog2(CODE_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [SIZE_W-1:0] in_size,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last
);

  localparam int unsigned FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] FILL_LIM = FILL_W'(ACC_W - CODE_W);
  localparam logic [FILL_W-1:0] BYTE_BITS = FILL_W'(8);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_EOI0,
    S_EOI1
  } state_t;

  state_t              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                stuff_q, stuff_d;
  logic                out_valid_q, out_valid_d;
  logic [7:0]          out_byte_q, out_byte_d;
  logic                out_last_q, out_last_d;

  logic                pop;
  logic                free;
  logic                accept;
  logic                ld;
  logic [7:0]          ld_byte;
  logic                ld_last;
  logic [ACC_W-1:0]    acc_post;
  logic [FILL_W-1:0]   fill_post;
  logic [CODE_W-1:0]   code_ones;
  logic [CODE_W-1:0]   code_m;
  logic [ACC_W-1:0]    code_wide;
  logic [7:0]          top_byte;

  assign in_ready  = (state_q == S_RUN) && (fill_q <= FILL_LIM) && !rst;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;

  assign pop      = out_valid_q && out_ready;
  assign free     = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign top_byte = acc_q[ACC_W-1 -: 8];

  // Keep only the top in_size code bits so the accumulator below fill stays zero.
  assign code_ones = '1;
  assign code_m    = in_code & ~(code_ones >> in_size);
  assign code_wide = {code_m, {(ACC_W - CODE_W){1'b0}}};

  always_comb begin
    state_d     = state_q;
    stuff_d     = stuff_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_last_d  = out_last_q;
    acc_post    = acc_q;
    fill_post   = fill_q;
    ld          = 1'b0;
    ld_byte     = '0;
    ld_last     = 1'b0;

    if (pop) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_RUN, S_FLUSH: begin
        if (free) begin
          if (stuff_q) begin
            ld      = 1'b1;
            ld_byte = 8'h00;
            stuff_d = 1'b0;
          end else if (fill_q >= BYTE_BITS) begin
            ld        = 1'b1;
            ld_byte   = top_byte;
            acc_post  = acc_q << 8;
            fill_post = fill_q - BYTE_BITS;
            stuff_d   = (top_byte == 8'hFF);
          end else if (state_q == S_FLUSH && fill_q != '0) begin
            ld        = 1'b1;
            ld_byte   = top_byte | (8'hFF >> fill_q[2:0]);
            acc_post  = '0;
            fill_post = '0;
            stuff_d   = ((top_byte | (8'hFF >> fill_q[2:0])) == 8'hFF);
          end else if (state_q == S_FLUSH) begin
            state_d = S_EOI0;
          end
        end
      end
      S_EOI0: begin
        if (free) begin
          ld      = 1'b1;
          ld_byte = 8'hFF;
          state_d = S_EOI1;
        end
      end
      S_EOI1: begin
        // D9 is already in the output register: leave only once it is taken.
        if (out_valid_q && out_last_q) begin
          if (out_ready) begin
            state_d   = S_RUN;
            fill_post = '0;
          end
        end else if (free) begin
          ld      = 1'b1;
          ld_byte = 8'hD9;
          ld_last = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (ld) begin
      out_valid_d = 1'b1;
      out_byte_d  = ld_byte;
      out_last_d  = ld_last;
    end

    if (accept) begin
      acc_d  = acc_post | (code_wide >> fill_post);
      fill_d = fill_post + FILL_W'(in_size);
      if (in_last) begin
        state_d = S_FLUSH;
      end
    end else begin
      acc_d  = acc_post;
      fill_d = fill_post;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      fill_q      <= '0;
      acc_q       <= '0;
      stuff_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      acc_q       <= acc_d;
      stuff_q     <= stuff_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
